// File: rtl/l1_l2_arbiter_pkg.sv
// Cache request/feedback structs shared by L1 and L2, plus the arbiter state and client enums.
// Round-robin collision handling is selected by the ARB_ROUND_ROBIN_EN macro.
package l1_cache_types;
    typedef struct packed {
        logic [31:0]  mem_address;
        logic         mem_read;
        logic         mem_write;
        logic [255:0] mem_wdata256;
    } l1_cache_request;

    typedef struct packed {
        logic         mem_resp;
        logic [255:0] mem_rdata256;
    } l1_cache_feedback;

    localparam l1_cache_request REQ_ZERO = '{mem_address: 32'd0, mem_read: 1'b0,
                                              mem_write: 1'b0, mem_wdata256: 256'd0};
endpackage

package l1_arbiter_types;
    import l1_cache_types::*;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT_I = 3'd1,
        GRANT_D = 3'd2,
        RESP_I  = 3'd3,
        RESP_D  = 3'd4
    } arb_state_t;

    typedef enum logic {
        CLIENT_I = 1'b0,
        CLIENT_D = 1'b1
    } client_sel_t;

    function automatic logic is_pending(input l1_cache_request r);
        return r.mem_read | r.mem_write;
    endfunction
endpackage

// File: rtl/l1_l2_arbiter_if.sv
// Request/feedback pair between a cache requester (master) and a cache responder (slave).
interface l1_l2_arbiter_if;
    import l1_cache_types::*;

    l1_cache_request  req;
    l1_cache_feedback fb;

    modport master (output req, input fb);
    modport slave  (input req, output fb);
endinterface

// File: rtl/l1_l2_arbiter_priority.sv
// Collision winner select for the L1/L2 arbiter. With ARB_ROUND_ROBIN_EN the preferred
// client alternates after every grant; otherwise the D-cache always wins a collision.
module l1_arbiter_priority
    import l1_arbiter_types::*;
(
`ifdef ARB_ROUND_ROBIN_EN
    input  logic        clk,
    input  logic        rst_n,
    input  logic        grant_en,
`endif
    input  logic        i_pend,
    input  logic        d_pend,
    output client_sel_t winner
);

    client_sel_t pref_s;

`ifdef ARB_ROUND_ROBIN_EN
    client_sel_t ptr_r;

    // Preference pointer: after a grant, favour the client that was not just served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= CLIENT_D;
        end else if (grant_en) begin
            ptr_r <= (winner == CLIENT_D) ? CLIENT_I : CLIENT_D;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign pref_s = ptr_r;
`else
    assign pref_s = CLIENT_D;
`endif

    // Winner: a lone pending client wins outright, a collision goes to the preferred one
    always_comb begin
        winner = CLIENT_D;
        if (i_pend && !d_pend) begin
            winner = CLIENT_I;
        end else if (d_pend && !i_pend) begin
            winner = CLIENT_D;
        end else if (i_pend && d_pend) begin
            winner = pref_s;
        end else begin
            winner = CLIENT_D;
        end
    end

endmodule

// File: rtl/l1_l2_arbiter.sv
// Two-client (I-cache / D-cache) arbiter in front of a shared L2 with one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for alternating collision priority; default is fixed D-cache priority.
module l1_l2_arbiter
    import l1_cache_types::*;
    import l1_arbiter_types::*;
(
    input  logic            clk,
    input  logic            rst_n,
    l1_l2_arbiter_if.slave  icache,
    l1_l2_arbiter_if.slave  dcache,
    l1_l2_arbiter_if.master l2
);

    arb_state_t       state_r;
    arb_state_t       state_nxt_s;
    l1_cache_request  req_q;
    logic [255:0]     rdata_q;
    logic             i_pend_s;
    logic             d_pend_s;
    logic             grant_en_s;
    logic             in_grant_s;
    client_sel_t      winner_s;
    l1_cache_request  l2_req_s;
    l1_cache_feedback icache_fb_s;
    l1_cache_feedback dcache_fb_s;

    assign i_pend_s   = is_pending(icache.req);
    assign d_pend_s   = is_pending(dcache.req);
    assign grant_en_s = (state_r == IDLE) && (i_pend_s || d_pend_s);
    assign in_grant_s = (state_r == GRANT_I) || (state_r == GRANT_D);

    l1_arbiter_priority u_priority (
`ifdef ARB_ROUND_ROBIN_EN
        .clk      (clk),
        .rst_n    (rst_n),
        .grant_en (grant_en_s),
`endif
        .i_pend   (i_pend_s),
        .d_pend   (d_pend_s),
        .winner   (winner_s)
    );

    // Next-state selection; client inputs only matter in IDLE, L2 response only in GRANT
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_en_s) begin
                    state_nxt_s = (winner_s == CLIENT_D) ? GRANT_D : GRANT_I;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GRANT_I: begin
                if (l2.fb.mem_resp) begin
                    state_nxt_s = RESP_I;
                end else begin
                    state_nxt_s = GRANT_I;
                end
            end
            GRANT_D: begin
                if (l2.fb.mem_resp) begin
                    state_nxt_s = RESP_D;
                end else begin
                    state_nxt_s = GRANT_D;
                end
            end
            RESP_I:  state_nxt_s = IDLE;
            RESP_D:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture the winner's request at grant time and L2 read data when L2 answers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= REQ_ZERO;
            rdata_q <= 256'd0;
        end else begin
            if (grant_en_s) begin
                req_q <= (winner_s == CLIENT_D) ? dcache.req : icache.req;
            end else begin
                req_q <= req_q;
            end
            if (in_grant_s && l2.fb.mem_resp) begin
                rdata_q <= l2.fb.mem_rdata256;
            end else begin
                rdata_q <= rdata_q;
            end
        end
    end

    // Outputs decoded purely from flops; address/wdata keep their last captured value
    always_comb begin
        l2_req_s           = req_q;
        l2_req_s.mem_read  = req_q.mem_read & in_grant_s;
        l2_req_s.mem_write = req_q.mem_write & in_grant_s;
        icache_fb_s        = '{mem_resp: (state_r == RESP_I), mem_rdata256: rdata_q};
        dcache_fb_s        = '{mem_resp: (state_r == RESP_D), mem_rdata256: rdata_q};
    end

    assign l2.req    = l2_req_s;
    assign icache.fb = icache_fb_s;
    assign dcache.fb = dcache_fb_s;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Directed bench for l1_l2_arbiter; the L2 side is driven by hand with fixed latencies.
module tb_l1_l2_arbiter;
    import l1_cache_types::*;
    import l1_arbiter_types::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   l2_done  = 0;
    logic pref_d   = 1'b1;

    localparam logic [255:0] DATA_A5 = {32{8'hA5}};
    localparam logic [255:0] WD_1234 = {16{16'h1234}};
    localparam logic [255:0] DATA_E1 = {8{32'h0E1E_0E1E}};
    localparam logic [255:0] DATA_E2 = {8{32'h0E2E_0E2E}};
    localparam logic [255:0] DATA_SP = {8{32'hDEAD_BEEF}};

    always #5 clk = ~clk;

    l1_l2_arbiter_if icache_bus ();
    l1_l2_arbiter_if dcache_bus ();
    l1_l2_arbiter_if l2_bus ();

    l1_l2_arbiter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .icache (icache_bus),
        .dcache (dcache_bus),
        .l2     (l2_bus)
    );

    // Completed L2 transactions: request active while L2 answers
    always @(posedge clk) begin
        if (rst_n && (l2_bus.req.mem_read || l2_bus.req.mem_write) && l2_bus.fb.mem_resp)
            l2_done <= l2_done + 1;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(dcache_bus.req.mem_read && dcache_bus.req.mem_write))
                else $error("illegal dcache request with read and write set");
            assert (!(icache_bus.req.mem_read && icache_bus.req.mem_write))
                else $error("illegal icache request with read and write set");
        end
    end

    task automatic check(input string tag, input logic [289:0] obs, input logic [289:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_i(input logic rd, input logic [31:0] addr);
        icache_bus.req = '{mem_address: addr, mem_read: rd, mem_write: 1'b0, mem_wdata256: 256'd0};
    endtask

    task automatic drive_d(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [255:0] wdata);
        dcache_bus.req = '{mem_address: addr, mem_read: rd, mem_write: wr, mem_wdata256: wdata};
    endtask

    task automatic drive_l2(input logic resp, input logic [255:0] data);
        l2_bus.fb = '{mem_resp: resp, mem_rdata256: data};
    endtask

    // Both clients request in the same cycle; winner from the priority model, loser at r+3
    task automatic collide(input logic [31:0] i_addr, input logic [31:0] d_addr,
                           input logic [255:0] i_data, input logic [255:0] d_data);
        logic win_d;
        logic cur_d;
`ifdef ARB_ROUND_ROBIN_EN
        win_d = pref_d;
`else
        win_d = 1'b1;
`endif
        drive_i(1'b1, i_addr);
        drive_d(1'b1, 1'b0, d_addr, 256'd0);
        for (int k = 0; k < 2; k++) begin
            cur_d = (k == 0) ? win_d : !win_d;
            step();
            check("coll_addr", l2_bus.req.mem_address, cur_d ? d_addr : i_addr);
            check("coll_rd", l2_bus.req.mem_read, 1'b1);
            pref_d = !cur_d;
            drive_l2(1'b1, cur_d ? d_data : i_data);
            step();
            check("coll_resp_d", dcache_bus.fb.mem_resp, cur_d);
            check("coll_resp_i", icache_bus.fb.mem_resp, !cur_d);
            check("coll_data", cur_d ? dcache_bus.fb.mem_rdata256 : icache_bus.fb.mem_rdata256,
                  cur_d ? d_data : i_data);
            drive_l2(1'b0, 256'd0);
            step();
            if (cur_d) drive_d(1'b0, 1'b0, 32'd0, 256'd0);
            else       drive_i(1'b0, 32'd0);
            check("coll_gap_rd", l2_bus.req.mem_read, 1'b0);
        end
        step();
        check("coll_end_rd", l2_bus.req.mem_read, 1'b0);
    endtask

    initial begin
        int done0;
        drive_i(1'b0, 32'd0);
        drive_d(1'b0, 1'b0, 32'd0, 256'd0);
        drive_l2(1'b0, 256'd0);

        // Reset state
        step();
        step();
        check("rst_l2_req", l2_bus.req, 290'd0);
        check("rst_i_fb", icache_bus.fb, 290'd0);
        check("rst_d_fb", dcache_bus.fb, 290'd0);
        rst_n = 1'b1;
        step();
        check("idle_rd", l2_bus.req.mem_read, 1'b0);

        // D-cache read alone, L2 answers three cycles into the grant
        drive_d(1'b1, 1'b0, 32'h0000_1000, 256'd0);
        step();
        check("a_addr", l2_bus.req.mem_address, 32'h0000_1000);
        check("a_rd1", l2_bus.req.mem_read, 1'b1);
        pref_d = 1'b0;
        step();
        check("a_rd2", l2_bus.req.mem_read, 1'b1);
        step();
        check("a_rd3", l2_bus.req.mem_read, 1'b1);
        step();
        check("a_rd4", l2_bus.req.mem_read, 1'b1);
        drive_l2(1'b1, DATA_A5);
        step();
        check("a_d_resp", dcache_bus.fb.mem_resp, 1'b1);
        check("a_d_data", dcache_bus.fb.mem_rdata256, DATA_A5);
        check("a_i_resp", icache_bus.fb.mem_resp, 1'b0);
        check("a_rd_resp", l2_bus.req.mem_read, 1'b0);
        drive_l2(1'b0, 256'd0);
        step();
        check("a_d_resp_off", dcache_bus.fb.mem_resp, 1'b0);
        drive_d(1'b0, 1'b0, 32'd0, 256'd0);
        step();
        check("a_idle_rd", l2_bus.req.mem_read, 1'b0);

        // D-cache write; client wdata/addr toggled during the grant must not reach L2
        drive_d(1'b0, 1'b1, 32'h0000_2020, WD_1234);
        step();
        check("b_addr1", l2_bus.req.mem_address, 32'h0000_2020);
        check("b_wr1", l2_bus.req.mem_write, 1'b1);
        check("b_rd1", l2_bus.req.mem_read, 1'b0);
        check("b_wd1", l2_bus.req.mem_wdata256, WD_1234);
        pref_d = 1'b0;
        drive_d(1'b0, 1'b1, 32'h0000_2020, ~WD_1234);
        step();
        check("b_wr2", l2_bus.req.mem_write, 1'b1);
        check("b_wd2", l2_bus.req.mem_wdata256, WD_1234);
        drive_d(1'b0, 1'b1, 32'h0000_3030, ~WD_1234);
        step();
        check("b_addr3", l2_bus.req.mem_address, 32'h0000_2020);
        check("b_wd3", l2_bus.req.mem_wdata256, WD_1234);
        drive_l2(1'b1, 256'd7);
        step();
        check("b_d_resp", dcache_bus.fb.mem_resp, 1'b1);
        check("b_wr_resp", l2_bus.req.mem_write, 1'b0);
        drive_l2(1'b0, 256'd0);
        step();
        drive_d(1'b0, 1'b0, 32'd0, 256'd0);
        check("b_hold_addr", l2_bus.req.mem_address, 32'h0000_2020);
        check("b_hold_wd", l2_bus.req.mem_wdata256, WD_1234);
        step();
        check("b_idle_wr", l2_bus.req.mem_write, 1'b0);

        // Two collisions in a row
        collide(32'h0000_3000, 32'h0000_4000, {8{32'h1111_0001}}, {8{32'hDDDD_0001}});
        collide(32'h0000_3100, 32'h0000_4100, {8{32'h1111_0002}}, {8{32'hDDDD_0002}});

        // Asynchronous reset while in GRANT_D
        drive_d(1'b1, 1'b0, 32'h0000_5000, 256'd0);
        step();
        check("r_grant_rd", l2_bus.req.mem_read, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("r_l2_req", l2_bus.req, 290'd0);
        check("r_d_fb", dcache_bus.fb, 290'd0);
        check("r_i_fb", icache_bus.fb, 290'd0);
        drive_d(1'b0, 1'b0, 32'd0, 256'd0);
        drive_l2(1'b0, 256'd0);
        pref_d = 1'b1;
        step();
        rst_n = 1'b1;
        drive_i(1'b1, 32'h0000_6000);
        step();
        check("r_i_addr", l2_bus.req.mem_address, 32'h0000_6000);
        check("r_i_rd", l2_bus.req.mem_read, 1'b1);
        pref_d = 1'b1;
        drive_l2(1'b1, {8{32'h6666_6666}});
        step();
        check("r_i_resp", icache_bus.fb.mem_resp, 1'b1);
        check("r_i_data", icache_bus.fb.mem_rdata256, {8{32'h6666_6666}});
        drive_l2(1'b0, 256'd0);
        step();
        drive_i(1'b0, 32'd0);
        step();
        check("r_idle_rd", l2_bus.req.mem_read, 1'b0);

        // Back-to-back D reads: drop at r+2, re-raise at r+3 with a new address
        done0 = l2_done;
        drive_d(1'b1, 1'b0, 32'h0000_7000, 256'd0);
        step();
        check("e_addr1", l2_bus.req.mem_address, 32'h0000_7000);
        pref_d = 1'b0;
        drive_l2(1'b1, DATA_E1);
        step();
        check("e_resp1", dcache_bus.fb.mem_rdata256, DATA_E1);
        drive_l2(1'b0, 256'd0);
        step();
        drive_d(1'b0, 1'b0, 32'd0, 256'd0);
        check("e_gap_rd", l2_bus.req.mem_read, 1'b0);
        step();
        drive_d(1'b1, 1'b0, 32'h0000_7040, 256'd0);
        check("e_gap2_rd", l2_bus.req.mem_read, 1'b0);
        step();
        check("e_addr2", l2_bus.req.mem_address, 32'h0000_7040);
        check("e_rd2", l2_bus.req.mem_read, 1'b1);
        drive_l2(1'b1, DATA_E2);
        step();
        check("e_resp2", dcache_bus.fb.mem_resp, 1'b1);
        check("e_data2", dcache_bus.fb.mem_rdata256, DATA_E2);
        drive_l2(1'b0, 256'd0);
        step();
        drive_d(1'b0, 1'b0, 32'd0, 256'd0);
        check("e_end_rd", l2_bus.req.mem_read, 1'b0);
        step();
        check("e_idle_rd", l2_bus.req.mem_read, 1'b0);
        check("e_l2_count", l2_done - done0, 2);

        // Spurious L2 response in IDLE
        drive_l2(1'b1, DATA_SP);
        step();
        check("f_d_resp", dcache_bus.fb.mem_resp, 1'b0);
        check("f_i_resp", icache_bus.fb.mem_resp, 1'b0);
        check("f_rd", l2_bus.req.mem_read, 1'b0);
        check("f_rdata_kept", dcache_bus.fb.mem_rdata256, DATA_E2);
        drive_l2(1'b0, 256'd0);
        step();
        check("f_d_resp2", dcache_bus.fb.mem_resp, 1'b0);
        drive_d(1'b1, 1'b0, 32'h0000_8000, 256'd0);
        step();
        check("f_grant_addr", l2_bus.req.mem_address, 32'h0000_8000);
        check("f_grant_rd", l2_bus.req.mem_read, 1'b1);
        drive_l2(1'b1, 256'd1);
        step();
        check("f_resp", dcache_bus.fb.mem_resp, 1'b1);
        drive_l2(1'b0, 256'd0);
        step();
        drive_d(1'b0, 1'b0, 32'd0, 256'd0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/l1_l2_arbiter.md
# l1_l2_arbiter

Two-client arbiter between the L1 instruction cache and L1 data cache and the shared L2 cache. Each L1 presents an `l1_cache_request` and receives an `l1_cache_feedback`. The arbiter grants one client at a time, holds a registered copy of its request toward L2 until L2 responds, and returns the registered 256-bit response to the winner. Requests are non-preemptive, and only one L2 transaction is in flight at any time.

## Interface
- No parameters. Line width of 256 and address width of 32 are fixed by the `l1_cache_types` structs.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `icache_req`  in  `l1_cache_request`  request from the L1 I-cache; `mem_write` is always 0 from this client.
- `icache_fb`  out  `l1_cache_feedback`  response to the I-cache.
- `dcache_req`  in  `l1_cache_request`  request from the L1 D-cache.
- `dcache_fb`  out  `l1_cache_feedback`  response to the D-cache.
- `l2_req`  out  `l1_cache_request`  request to the L2 cache.
- `l2_fb`  in  `l1_cache_feedback`  response from the L2 cache.

## Operation
- A client is *pending* when `mem_read | mem_write` is 1. Both bits set from one client is illegal; the bench asserts on it.
- **States:** IDLE, GRANT_I, GRANT_D, RESP_I, RESP_D.
- **IDLE:**
  - If exactly one client is pending, go to its GRANT state.
  - If both are pending, the priority rule picks the winner (see Configuration).
  - On the transition, the winner's full request (addr, read, write, wdata256) is captured into `req_q`.
- **GRANT_x:**
  - `l2_req = req_q`.
  - Client inputs are ignored, so changes there do not disturb L2.
  - When `l2_fb.mem_resp` is 1, capture `l2_fb.mem_rdata256` into `rdata_q` and go to RESP_x.
- **RESP_x:**
  - `x_fb.mem_resp = 1` for exactly this cycle, with `x_fb.mem_rdata256 = rdata_q`.
  - `l2_req.mem_read` and `l2_req.mem_write` are 0.
  - Next state is IDLE unconditionally.
- **Idle outputs:** the non-granted client's `mem_resp` is always 0. Each client's `mem_rdata256` is always driven from `rdata_q`, regardless of grant.
- **l2_req outside GRANT:** read and write are 0, and address and wdata hold their last `req_q` value.
- **Reset** (asynchronous, any state, including mid-transaction):
  - state becomes IDLE;
  - `req_q` and `rdata_q` clear to 0;
  - every output struct reads 0;
  - the priority pointer is set to D-cache.
  - The L2 side must itself be reset in the same event.

## Timing
- Client raises a request in cycle t with the arbiter in IDLE → state GRANT at t+1 → `l2_req` asserted from t+1.
- L2 asserts `mem_resp` in cycle r → client `mem_resp` in cycle r+1 → arbiter back in IDLE at r+2.
- Client contract: the client deasserts its request in the cycle after it sees `mem_resp`. The arbiter therefore samples the deasserted request at r+2, and no request is ever serviced twice.
- Minimum round trip for one client is (L2 latency) + 2 cycles.
- The loser of a collision stays pending and is granted at r+2 of the winner's transaction, so `l2_req` is asserted again at r+3.
- L2 `mem_resp` arriving in any state other than GRANT is ignored.

## Configuration
- **`ARB_ROUND_ROBIN_EN` defined:**
  - A 1-bit pointer names the preferred client on a collision.
  - After any grant, the pointer moves to the other client.
  - The pointer resets to D-cache.
- **Undefined:** fixed priority, D-cache always wins a collision. The pointer register is not instantiated.

## Structure
- Shared package `l1_arbiter_types`:
  - imports `l1_cache_types`;
  - defines enum `arb_state_t` for the five states and a `client_sel_t` enum {CLIENT_I, CLIENT_D}.
- One sub-module, `l1_arbiter_priority`:
  - combinational winner select from the two pending bits and the pointer;
  - holds the round-robin pointer flop under the macro.
  - All other logic stays in the top module.

## Test plan
- **D-cache read alone:** addr 0x0000_1000, L2 responds after 3 cycles with 256'hA5… → `dcache_fb.mem_resp` for one cycle at request+5 with data A5…; `icache_fb.mem_resp` stays 0.
- **D-cache write:** addr 0x0000_2020, wdata 256'h1234… → `l2_req` shows identical addr/write/wdata for every GRANT cycle, even while `dcache_req.wdata` is toggled.
- **Simultaneous I and D reads, fixed priority:** D is served first, then I, with `l2_req` reasserted at the D response cycle +2. With `ARB_ROUND_ROBIN_EN`, a second collision serves I first.
- **Reset in GRANT_D:**
  - stimulus: `rst_n` low mid-transaction;
  - response: outputs 0 within the same cycle, state IDLE;
  - after release, a new I-cache request is granted normally.
- **Back-to-back D reads:**
  - stimulus: client drops its request at r+2 and re-raises it at r+3 with a new address;
  - response: exactly two L2 transactions, and no duplicate of the first address.
- **Spurious L2 response:** `l2_fb.mem_resp` pulsed in IDLE → no client `mem_resp` and no state change.
